// File: rtl/fpu_issue_queue.sv
// fpu_issue_queue: request FIFO -> EX register -> WB register around an external
// combinational bfloat16 fpu. One op per cycle, full backpressure from the response side.
// Optional build macro FPU_ISSUE_PERF_EN adds saturating perf_ops_o / perf_ovf_o counters.

module fpu_issue_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic [3:0]    req_op_i,
  input  logic [15:0]   req_in1_i,
  input  logic [15:0]   req_in2_i,
  output logic [3:0]    fpu_op_o,
  output logic [15:0]   fpu_in1_o,
  output logic [15:0]   fpu_in2_o,
  input  logic [15:0]   fpu_out_i,
  input  logic          fpu_overflow_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [15:0]   rsp_data_o,
  output logic          rsp_overflow_o,
  output logic          rsp_illegal_o,
  output logic [AW:0]   count_o
`ifdef FPU_ISSUE_PERF_EN
  ,
  output logic [31:0]   perf_ops_o,
  output logic [15:0]   perf_ovf_o
`endif
);

  localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);
  localparam logic [15:0] IllegalNaN = 16'h7FC0;

  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] in1;
    logic [15:0] in2;
  } req_t;

  req_t          mem_q [DEPTH];
  req_t          head;
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [AW:0]   count_q;
  logic          ex_valid_q, wb_valid_q;
  logic          push, pop, wb_free, ex_free, ex_illegal, rsp_fire;

  // Full FIFO never accepts, even if the head leaves this same cycle
  assign req_ready_o = (count_q != FullCount) & ~flush_i;
  assign push        = req_valid_i & req_ready_o;
  assign wb_free     = ~wb_valid_q | rsp_ready_i;
  assign ex_free     = ~ex_valid_q | wb_free;
  assign pop         = ex_free & (count_q != '0);
  assign head        = mem_q[rd_ptr_q];
  assign ex_illegal  = (fpu_op_o == 4'b0000) | ((fpu_op_o & (fpu_op_o - 4'd1)) != 4'b0000);
  assign rsp_fire    = wb_valid_q & rsp_ready_i;
  assign count_o     = count_q;
  assign rsp_valid_o = wb_valid_q;

  // Storage array: only written on push, entries are qualified by count_q
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {req_op_i, req_in1_i, req_in2_i};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at 2**AW
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // EX stage: operand registers hold when idle, ex_valid_q qualifies them
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ex_valid_q <= 1'b0;
      fpu_op_o   <= '0;
      fpu_in1_o  <= '0;
      fpu_in2_o  <= '0;
    end else if (flush_i) begin
      ex_valid_q <= 1'b0;
    end else if (pop) begin
      ex_valid_q <= 1'b1;
      fpu_op_o   <= head.op;
      fpu_in1_o  <= head.in1;
      fpu_in2_o  <= head.in2;
    end else if (wb_free) begin
      ex_valid_q <= 1'b0;
    end
  end

  // WB stage: capture fpu result, substitute quiet NaN for non-one-hot ops
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wb_valid_q     <= 1'b0;
      rsp_data_o     <= '0;
      rsp_overflow_o <= 1'b0;
      rsp_illegal_o  <= 1'b0;
    end else if (flush_i) begin
      wb_valid_q <= 1'b0;
    end else if (ex_valid_q && wb_free) begin
      wb_valid_q <= 1'b1;
      if (ex_illegal) begin
        rsp_data_o     <= IllegalNaN;
        rsp_overflow_o <= 1'b0;
        rsp_illegal_o  <= 1'b1;
      end else begin
        rsp_data_o     <= fpu_out_i;
        rsp_overflow_o <= fpu_overflow_i;
        rsp_illegal_o  <= 1'b0;
      end
    end else if (wb_free) begin
      wb_valid_q <= 1'b0;
    end
  end

`ifdef FPU_ISSUE_PERF_EN
  // Saturating handshake counters; a delivery during flush still counts
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_ops_o <= '0;
      perf_ovf_o <= '0;
    end else if (rsp_fire) begin
      if (perf_ops_o != '1) perf_ops_o <= perf_ops_o + 1'b1;
      if (rsp_overflow_o && (perf_ovf_o != '1)) perf_ovf_o <= perf_ovf_o + 1'b1;
    end
  end
`else
  logic unused_fire;
  assign unused_fire = rsp_fire;
`endif

endmodule

// File: tb/tb_fpu_issue_queue.sv
// Scoreboard bench for fpu_issue_queue with a stub combinational fpu.
module tb_fpu_issue_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, req_valid, req_ready, rsp_valid, rsp_ready;
  logic [3:0]  req_op, fpu_op;
  logic [15:0] req_in1, req_in2, fpu_in1, fpu_in2, fpu_out, rsp_data;
  logic        fpu_ovf, rsp_overflow, rsp_illegal;
  logic [2:0]  count;
`ifdef FPU_ISSUE_PERF_EN
  logic [31:0] perf_ops;
  logic [15:0] perf_ovf;
`endif

  always #5 clk = ~clk;

  fpu_issue_queue #(.DEPTH(4), .AW(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
    .req_in1_i(req_in1), .req_in2_i(req_in2),
    .fpu_op_o(fpu_op), .fpu_in1_o(fpu_in1), .fpu_in2_o(fpu_in2),
    .fpu_out_i(fpu_out), .fpu_overflow_i(fpu_ovf),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .rsp_overflow_o(rsp_overflow), .rsp_illegal_o(rsp_illegal), .count_o(count)
`ifdef FPU_ISSUE_PERF_EN
    , .perf_ops_o(perf_ops), .perf_ovf_o(perf_ovf)
`endif
  );

  // Stub fpu: exact bf16 results for the directed cases, a deterministic mix otherwise
  function automatic logic [16:0] fpu_model(input logic [3:0] op, input logic [15:0] a,
                                            input logic [15:0] b);
    case ({op, a, b})
      {4'b0001, 16'h3F80, 16'h3F80}: return {1'b0, 16'h4000};
      {4'b0100, 16'h4000, 16'h4000}: return {1'b0, 16'h4080};
      {4'b1000, 16'h3F80, 16'h4000}: return {1'b0, 16'h3F00};
      {4'b0010, 16'h4000, 16'h3F80}: return {1'b0, 16'h3F80};
      {4'b0100, 16'h7F00, 16'h7F00}: return {1'b1, 16'h7F80};
      default: return {a[15] & b[15] & op[2], 16'((a ^ {b[7:0], b[15:8]}) + {12'h0, op})};
    endcase
  endfunction

  always_comb {fpu_ovf, fpu_out} = fpu_model(fpu_op, fpu_in1, fpu_in2);

  // Expected response {illegal, overflow, data} from the request alone
  function automatic logic [17:0] exp_of(input logic [3:0] op, input logic [15:0] a,
                                         input logic [15:0] b);
    if ($countones(op) != 1) return {2'b10, 16'h7FC0};
    return {1'b0, fpu_model(op, a, b)};
  endfunction

  int total = 0;
  int bad = 0;
  int n_deliv = 0;
  logic [17:0] exp_q[$];
  logic        hold_v;
  logic [17:0] hold_d;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // Monitor: pops and compares on every response handshake, checks hold stability
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      hold_v = 1'b0;
    end else begin
      if (hold_v && rsp_valid) chk("rsp_hold", 64'({rsp_illegal, rsp_overflow, rsp_data}),
                                   64'(hold_d));
      if (rsp_valid && rsp_ready) begin
        n_deliv++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rsp_unexpected got=%0h exp=none", rsp_data);
        end else begin
          chk("rsp_result", 64'({rsp_illegal, rsp_overflow, rsp_data}), 64'(exp_q.pop_front()));
        end
      end
      hold_v = rsp_valid && !rsp_ready;
      hold_d = {rsp_illegal, rsp_overflow, rsp_data};
      if (flush) exp_q.delete();
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    int k = 0;
    req_valid = 1'b1;
    req_op = op;
    req_in1 = a;
    req_in2 = b;
    forever begin
      @(negedge clk);
      if (req_ready) begin
        exp_q.push_back(exp_of(op, a, b));
        break;
      end
      k++;
      if (k > 50) begin
        total++;
        bad++;
        $display("FAIL send_timeout got=stalled exp=accepted");
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Called right after send returns: push edge T -> rsp_valid after T+2
  task automatic lat_check(input logic [15:0] d);
    chk("lat_t0", 64'(rsp_valid), 64'(0));
    @(posedge clk); #1;
    chk("lat_t1", 64'(rsp_valid), 64'(0));
    @(posedge clk); #1;
    chk("lat_t2", 64'(rsp_valid), 64'(1));
    chk("lat_data", 64'(rsp_data), 64'(d));
    chk("lat_ovf", 64'(rsp_overflow), 64'(0));
  endtask

  task automatic drain();
    int k = 0;
    rsp_ready = 1'b1;
    while ((exp_q.size() != 0 || rsp_valid) && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    int n0;
    int k;
    logic [15:0] c2 [3];
    c2[0] = 16'h4080;
    c2[1] = 16'h3F00;
    c2[2] = 16'h3F80;
    rst_n = 1'b0;
    flush = 1'b0;
    req_valid = 1'b0;
    req_op = '0;
    req_in1 = '0;
    req_in2 = '0;
    rsp_ready = 1'b1;
    #12;
    chk("reset_outs", 64'({fpu_op, fpu_in1, fpu_in2, rsp_valid, rsp_data, rsp_overflow,
                           rsp_illegal, count}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_ready", 64'(req_ready), 64'(1));
    chk("reset_count", 64'(count), 64'(0));

    // Case 1: single add, latency
    send(4'b0001, 16'h3F80, 16'h3F80);
    lat_check(16'h4000);

    // Case 2: back-to-back mul/div/sub on consecutive cycles
    send(4'b0100, 16'h4000, 16'h4000);
    send(4'b1000, 16'h3F80, 16'h4000);
    send(4'b0010, 16'h4000, 16'h3F80);
    k = 0;
    while (!rsp_valid && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    for (int i = 0; i < 3; i++) begin
      chk("b2b_valid", 64'(rsp_valid), 64'(1));
      chk("b2b_data", 64'(rsp_data), 64'(c2[i]));
      @(posedge clk); #1;
    end
    drain();

    // Case 3: backpressure with 7 ops
    rsp_ready = 1'b0;
    n0 = n_deliv;
    for (int i = 0; i < 6; i++) send(4'(1 << (i % 4)), 16'(16'h3F80 + i), 16'(16'h4000 + 3 * i));
    req_valid = 1'b1;
    req_op = 4'b0001;
    req_in1 = 16'h1234;
    req_in2 = 16'h0101;
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("full_ready", 64'(req_ready), 64'(0));
    chk("full_count", 64'(count), 64'(4));
    chk("full_rsp_valid", 64'(rsp_valid), 64'(1));
    rsp_ready = 1'b1;
    send(4'b0001, 16'h1234, 16'h0101);
    drain();
    chk("bp_delivered", 64'(n_deliv - n0), 64'(7));

    // Case 4: illegal op and overflow
    send(4'b0011, 16'h3F80, 16'h3F80);
    send(4'b0100, 16'h7F00, 16'h7F00);
    drain();
`ifdef FPU_ISSUE_PERF_EN
    chk("perf_ops", 64'(perf_ops), 64'(13));
    chk("perf_ovf", 64'(perf_ovf), 64'(1));
`endif

    // Case 5: flush with 3 queued plus EX and WB occupied
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(4'b0010, 16'(16'h0100 + i), 16'h0200);
    chk("pre_flush_count", 64'(count), 64'(3));
    flush = 1'b1;
    #1;
    chk("flush_ready", 64'(req_ready), 64'(0));
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_count", 64'(count), 64'(0));
    chk("flush_rsp_valid", 64'(rsp_valid), 64'(0));
    rsp_ready = 1'b1;
    send(4'b0001, 16'h3F80, 16'h3F80);
    lat_check(16'h4000);
    drain();

    // Random traffic with random backpressure and occasional flush
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      req_valid = ($urandom_range(0, 3) != 0);
      req_op = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
      req_in1 = 16'($urandom);
      req_in2 = 16'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 39) == 0);
      @(negedge clk);
      if (req_valid && req_ready) exp_q.push_back(exp_of(req_op, req_in1, req_in2));
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    flush = 1'b0;
    drain();

    // Case 6: async reset mid-stream
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(4'b0100, 16'(16'h0300 + i), 16'h0011);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_outs", 64'({fpu_op, fpu_in1, fpu_in2, rsp_valid, rsp_data, rsp_overflow,
                          rsp_illegal, count}), 64'(0));
    chk("arst_ready", 64'(req_ready), 64'(1));
`ifdef FPU_ISSUE_PERF_EN
    chk("arst_perf", 64'({perf_ops, perf_ovf}), 64'(0));
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    send(4'b0001, 16'h3F80, 16'h3F80);
    lat_check(16'h4000);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
